// File: rtl/decoder_seq_if.sv
// rtl/decoder_seq_if.sv - select/decode bus between a driver and decoder_seq
interface decoder_seq_if #(
  parameter int SEL_W = 2
);
  logic               e;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   a;
  logic [2**SEL_W-1:0] y;
  logic               valid;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (
    output e, mode, load, a,
    input  y, valid, idx, wrap
  );

  modport slave (
    input  e, mode, load, a,
    output y, valid, idx, wrap
  );
endinterface

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - registered one-hot decoder with scan sequencer compiled in by DECODER_SEQ_SCAN_EN
module decoder_seq #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input logic          clk,
  input logic          rst_n,
  decoder_seq_if.slave bus
);
  localparam int N = 2 ** SEL_W;

`ifdef DECODER_SEQ_SCAN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2} state_t;
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [N-1:0]     y_q, y_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;

  // Next state and next outputs; y is always derived from the next index so it stays one-hot or zero.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
`ifdef DECODER_SEQ_SCAN_EN
    cnt_d   = cnt_q;
`endif
    if (!bus.e) begin
      state_d = IDLE;
      valid_d = 1'b0;
`ifdef DECODER_SEQ_SCAN_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef DECODER_SEQ_SCAN_EN
          if (bus.mode) begin
            state_d = SCAN;
            idx_d   = bus.a;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else
`endif
          if (bus.load) begin
            state_d = DIRECT;
            idx_d   = bus.a;
            valid_d = 1'b1;
          end
        end
        DIRECT: begin
`ifdef DECODER_SEQ_SCAN_EN
          if (bus.mode) begin
            state_d = SCAN;
            cnt_d   = '0;
          end else
`endif
          if (bus.load) begin
            idx_d = bus.a;
          end
        end
`ifdef DECODER_SEQ_SCAN_EN
        SCAN: begin
          if (!bus.mode) begin
            state_d = DIRECT;
          end else if (cnt_q == DWELL_LAST) begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = '0;
            wrap_d = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
    y_d = '0;
    if (valid_d) begin
      y_d[idx_d] = 1'b1;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef DECODER_SEQ_SCAN_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
`ifdef DECODER_SEQ_SCAN_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - self-checking bench for decoder_seq (scan tests when DECODER_SEQ_SCAN_EN is defined)
module tb_decoder_seq;
  localparam int SEL_W = 2;
  localparam int DWELL = 4;
  localparam int N     = 4;
`ifdef DECODER_SEQ_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  decoder_seq_if #(.SEL_W(SEL_W)) bus ();

  decoder_seq #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: scan position is start index plus elapsed dwell periods.
  bit m_active, m_scan;
  int m_idx, m_start, m_age;

  function automatic int m_cur_idx();
    return m_scan ? (m_start + m_age / DWELL) % N : m_idx;
  endfunction

  function automatic logic [3:0] m_y();
    return m_active ? 4'(1 << m_cur_idx()) : 4'b0000;
  endfunction

  function automatic logic m_wrap();
    return m_scan && m_age > 0 && (m_age % DWELL) == 0 && m_cur_idx() == 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_scan = 0; m_idx = 0; m_start = 0; m_age = 0;
  endtask

  task automatic model_step(input logic e, input logic mode, input logic load, input logic [1:0] a);
    if (!e) begin
      m_idx = m_cur_idx(); m_active = 0; m_scan = 0;
    end else if (!m_active) begin
      if (SCAN_EN && mode) begin
        m_active = 1; m_scan = 1; m_start = a; m_age = 0;
      end else if (load) begin
        m_active = 1; m_idx = a;
      end
    end else if (m_scan) begin
      if (!mode) begin
        m_idx = m_cur_idx(); m_scan = 0;
      end else begin
        m_age++;
      end
    end else begin
      if (SCAN_EN && mode) begin
        m_scan = 1; m_start = m_idx; m_age = 0;
      end else if (load) begin
        m_idx = a;
      end
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic e, input logic mode, input logic load, input logic [1:0] a);
    @(negedge clk);
    bus.e = e; bus.mode = mode; bus.load = load; bus.a = a;
    @(posedge clk);
    model_step(e, mode, load, a);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.e = 1'b1; bus.mode = 1'($urandom); bus.load = 1'b1; bus.a = 2'($urandom);
    #2;
    total++; if (bus.y !== 4'b0000) begin bad++; $display("FAIL reset_y: got %b want 0000", bus.y); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    total++; if (bus.idx !== 2'b00) begin bad++; $display("FAIL reset_idx: got %b want 00", bus.idx); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", bus.wrap); end
    @(negedge clk);
    bus.e = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 1'b1, 2'd3);
    total++; if (bus.y !== 4'b1000) begin bad++; $display("FAIL reset_pre_y: got %b want 1000", bus.y); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.y !== 4'b0000 || bus.valid !== 1'b0 || bus.idx !== 2'b00) begin
      bad++; $display("FAIL reset_async: got y=%b v=%b idx=%b want 0000/0/00", bus.y, bus.valid, bus.idx);
    end
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_direct();
    logic [1:0] as [4];
    logic [3:0] ys [4];
    as = '{2'd1, 2'd2, 2'd3, 2'd0};
    ys = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cyc(1'b0, 1'b0, 1'b1, 2'd2);
    total++; if (bus.y !== 4'b0000 || bus.valid !== 1'b0) begin
      bad++; $display("FAIL direct_disabled: got y=%b v=%b want 0000/0", bus.y, bus.valid);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, as[i]);
      total++; if (bus.y !== ys[i] || bus.valid !== 1'b1 || bus.idx !== as[i] || bus.wrap !== 1'b0) begin
        bad++; $display("FAIL direct_load[%0d]: got y=%b v=%b idx=%b w=%b want y=%b v=1 idx=%b w=0",
                        i, bus.y, bus.valid, bus.idx, bus.wrap, ys[i], as[i]);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 2'd3);
    total++; if (bus.y !== 4'b0001 || bus.idx !== 2'd0) begin
      bad++; $display("FAIL direct_hold: got y=%b idx=%b want 0001/00", bus.y, bus.idx);
    end
  endtask

`ifdef DECODER_SEQ_SCAN_EN
  task automatic test_scan();
    logic [3:0] ys [13];
    ys = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
           4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 13; k++) begin
      cyc(1'b1, 1'b1, 1'($urandom), 2'd2);
      total++; if (bus.y !== ys[k] || bus.wrap !== (k == 8) || bus.valid !== 1'b1) begin
        bad++; $display("FAIL scan_seq[%0d]: got y=%b w=%b v=%b want y=%b w=%b v=1",
                        k, bus.y, bus.wrap, bus.valid, ys[k], (k == 8));
      end
    end
  endtask

  task automatic test_e_drop();
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'd3);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 1'b1, 2'd0);
    total++; if (bus.y !== 4'b0000 || bus.valid !== 1'b0 || bus.idx !== 2'd3 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL edrop: got y=%b v=%b idx=%b w=%b want 0000/0/11/0", bus.y, bus.valid, bus.idx, bus.wrap);
    end
    cyc(1'b1, 1'b1, 1'b0, 2'd1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b0, 2'd1);
    total++; if (bus.y !== 4'b0100) begin bad++; $display("FAIL midscan_pre: got %b want 0100", bus.y); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.y !== 4'b0000 || bus.valid !== 1'b0 || bus.idx !== 2'd0 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL midscan_rst: got y=%b v=%b idx=%b w=%b want 0000/0/00/0", bus.y, bus.valid, bus.idx, bus.wrap);
    end
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 2'd3);
      total++; if (bus.y !== ((k < 4) ? 4'b1000 : 4'b0001) || bus.wrap !== (k == 4)) begin
        bad++; $display("FAIL rescan[%0d]: got y=%b w=%b want y=%b w=%b",
                        k, bus.y, bus.wrap, ((k < 4) ? 4'b1000 : 4'b0001), (k == 4));
      end
    end
  endtask

  task automatic test_scan_to_direct();
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd1);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'($urandom));
      total++; if (bus.y !== 4'b0010 || bus.wrap !== 1'b0 || bus.valid !== 1'b1) begin
        bad++; $display("FAIL s2d_hold[%0d]: got y=%b w=%b v=%b want 0010/0/1", k, bus.y, bus.wrap, bus.valid);
      end
    end
    cyc(1'b1, 1'b0, 1'b1, 2'd3);
    total++; if (bus.y !== 4'b1000) begin bad++; $display("FAIL s2d_load: got %b want 1000", bus.y); end
  endtask
`else
  task automatic test_no_scan();
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 21; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 2'd2);
      total++; if (bus.y !== 4'b0100 || bus.wrap !== 1'b0 || bus.valid !== 1'b1) begin
        bad++; $display("FAIL noscan[%0d]: got y=%b w=%b v=%b want 0100/0/1", k, bus.y, bus.wrap, bus.valid);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0) ^ 1'(i[6]),
          1'($urandom), 2'($urandom));
      total++; if (bus.y !== m_y() || bus.valid !== m_active || bus.idx !== 2'(m_cur_idx()) || bus.wrap !== m_wrap()) begin
        bad++; $display("FAIL rand[%0d]: got y=%b v=%b idx=%0d w=%b want y=%b v=%b idx=%0d w=%b",
                        i, bus.y, bus.valid, bus.idx, bus.wrap, m_y(), m_active, m_cur_idx(), m_wrap());
      end
      if ($urandom_range(0, 59) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_direct();
`ifdef DECODER_SEQ_SCAN_EN
    test_scan();
    test_e_drop();
    test_scan_to_direct();
`else
    test_no_scan();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
